// File: rtl/rf_debug_arbiter_pkg.sv
// Shared encodings for the register-file debug arbiter: FSM states and
// register-index width.
package rf_debug_arbiter_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_BND = 3'd1,
    ST_ACCESS   = 3'd2,
    ST_CLEAR    = 3'd3,
    ST_ACK      = 3'd4
  } arb_state_e;

endpackage

// File: rtl/rf_debug_arbiter_clear_sweeper.sv
// Register index generator for the zero-sweep: idx runs 1..NUM_REGS-1 while
// enabled and flags the final index so the FSM can leave CLEAR.
module rf_clear_sweeper
  import rf_debug_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_i,
  output logic [REG_IDX_W-1:0] idx_o,
  output logic                 last_o
);

  localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(NUM_REGS - 1);

  logic [REG_IDX_W-1:0] idx_q, idx_d;

  // Reloading 1 whenever idle means the first CLEAR cycle always targets $1.
  always_comb idx_d = en_i ? idx_q + REG_IDX_W'(1) : REG_IDX_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) idx_q <= '0;
    else       idx_q <= idx_d;
  end

  assign idx_o  = idx_q;
  assign last_o = en_i && (idx_q == LAST_IDX);

endmodule

// File: rtl/rf_debug_arbiter.sv
// Shares the register file write port and read port 1 between the CPU and a
// host/debug interface; debug accesses and clears happen only at IF boundaries.
module rf_debug_arbiter
  import rf_debug_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_reg_write,
  input  logic [4:0]  cpu_write_register,
  input  logic [31:0] cpu_write_data,
  input  logic [4:0]  cpu_read_register1,
  input  logic        cpu_boundary,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic        dbg_err,
  output logic [31:0] dbg_rdata,
  input  logic        dbg_clear,
  output logic        clr_done,
  output logic        dbg_busy,
  output logic        rf_reg_write,
  output logic [4:0]  rf_write_register,
  output logic [31:0] rf_write_data,
  output logic [4:0]  rf_read_register1,
  input  logic [31:0] rf_read_data1
);

  arb_state_e     state_q, state_d;
  logic           stall_q, stall_d, ack_q, ack_d, err_q, err_d;
  logic           done_q, done_d, pend_q, pend_d;
  logic [31:0]    rdata_q, rdata_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           we_q, we_d;
  logic [4:0]     addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           latch_req, pend_drop, timeout;
  logic [REG_IDX_W-1:0] sweep_idx;
  logic           sweep_last;

  rf_clear_sweeper #(.NUM_REGS(NUM_REGS)) u_sweeper (
    .clk    (clk),
    .reset  (reset),
    .en_i   (state_q == ST_CLEAR),
    .idx_o  (sweep_idx),
    .last_o (sweep_last)
  );

  assign timeout = (WAIT_LIMIT != 0) && ((32'(cnt_q) + 32'd1) == WAIT_LIMIT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    done_d    = 1'b0;
    latch_req = 1'b0;
    pend_drop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        latch_req = dbg_req;
        if (pend_q || dbg_req) state_d = ST_WAIT_BND;
      end
      ST_WAIT_BND: begin
        if (cpu_boundary) begin
          pend_drop = pend_q;
          state_d   = pend_q ? ST_CLEAR : ST_ACCESS;
        end else if (timeout) begin
          // An abandoned clear only reports clr_done; the ack path is
          // reserved for a host that is actually waiting on dbg_req.
          pend_drop = pend_q;
          done_d    = pend_q;
          if (dbg_req) begin
            err_d   = 1'b1;
            state_d = ST_ACK;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_ACCESS: begin
        if (we_q)                    rdata_d = wdata_q;
        else if (addr_q == REG_ZERO) rdata_d = '0;
        else                         rdata_d = rf_read_data1;
        state_d = ST_ACK;
      end
      ST_CLEAR: begin
        if (sweep_last) begin
          done_d    = 1'b1;
          cnt_d     = '0;
          latch_req = dbg_req;
          state_d   = dbg_req ? ST_WAIT_BND : ST_IDLE;
        end
      end
      ST_ACK: begin
        if (!dbg_req) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A new pulse wins over the drop so a clear arriving on CLEAR entry is kept.
    pend_d  = dbg_clear | (pend_q & ~pend_drop);
    ack_d   = (state_d == ST_ACK);
    stall_d = (state_d != ST_IDLE);
    we_d    = latch_req ? dbg_we    : we_q;
    addr_d  = latch_req ? dbg_addr  : addr_q;
    wdata_d = latch_req ? dbg_wdata : wdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      stall_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request payload is only meaningful once latched, so it carries no reset.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    rf_reg_write      = cpu_reg_write;
    rf_write_register = cpu_write_register;
    rf_write_data     = cpu_write_data;
    rf_read_register1 = cpu_read_register1;
    case (state_q)
      ST_ACCESS: begin
        rf_reg_write      = we_q && (addr_q != REG_ZERO);
        rf_write_register = addr_q;
        rf_write_data     = wdata_q;
        rf_read_register1 = addr_q;
      end
      ST_CLEAR: begin
        rf_reg_write      = 1'b1;
        rf_write_register = sweep_idx;
        rf_write_data     = '0;
      end
      ST_ACK:  rf_reg_write = 1'b0;
      default: ;
    endcase
  end

  assign cpu_stall = stall_q;
  assign dbg_ack   = ack_q;
  assign dbg_err   = err_q;
  assign dbg_rdata = rdata_q;
  assign clr_done  = done_q;
  assign dbg_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rf_debug_arbiter.sv
// Bench for rf_debug_arbiter: behavioural register file, vector tables for
// pass-through and debug accesses, ack scoreboard, and corner-case sequences.
module tb_rf_debug_arbiter;

  localparam int unsigned TB_WAIT_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_reg_write, cpu_boundary, cpu_stall;
  logic [4:0]  cpu_write_register, cpu_read_register1;
  logic [31:0] cpu_write_data;
  logic        dbg_req, dbg_we, dbg_ack, dbg_err, dbg_clear, clr_done, dbg_busy;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic        rf_reg_write;
  logic [4:0]  rf_write_register, rf_read_register1;
  logic [31:0] rf_write_data, rf_read_data1;

  always #5 clk = ~clk;

  rf_debug_arbiter #(.WAIT_LIMIT(TB_WAIT_LIMIT), .NUM_REGS(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_reg_write(cpu_reg_write), .cpu_write_register(cpu_write_register),
    .cpu_write_data(cpu_write_data), .cpu_read_register1(cpu_read_register1),
    .cpu_boundary(cpu_boundary), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
    .dbg_clear(dbg_clear), .clr_done(clr_done), .dbg_busy(dbg_busy),
    .rf_reg_write(rf_reg_write), .rf_write_register(rf_write_register),
    .rf_write_data(rf_write_data), .rf_read_register1(rf_read_register1),
    .rf_read_data1(rf_read_data1)
  );

  // Behavioural register file plus a log of every write it receives.
  typedef struct { logic [4:0] addr; logic [31:0] data; int cyc; } wr_t;
  logic [31:0] rf [32] = '{default: 32'd0};
  wr_t wr_log[$];
  int  cyc = 0;
  int  zero_wr = 0;

  assign rf_read_data1 = (rf_read_register1 == 5'd0) ? 32'd0 : rf[rf_read_register1];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rf_reg_write) begin
      wr_log.push_back('{rf_write_register, rf_write_data, cyc});
      if (rf_write_register == 5'd0) zero_wr <= zero_wr + 1;
      else rf[rf_write_register] <= rf_write_data;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Ack scoreboard: expectations pushed at request time, popped on dbg_ack rise.
  typedef struct { logic [31:0] rdata; bit chk_rd; bit err; int lat; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   req_cyc = 0;
  int   clr_pulses = 0;
  logic ack_prev = 1'b0;

  always @(negedge clk) begin
    if (clr_done === 1'b1) clr_pulses <= clr_pulses + 1;
    if (dbg_ack === 1'b1 && ack_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ack_err", {31'd0, dbg_err}, {31'd0, mon_e.err});
        if (mon_e.chk_rd) chk("ack_rdata", dbg_rdata, mon_e.rdata);
        if (mon_e.lat >= 0) chk("ack_latency", 32'(cyc - req_cyc), 32'(mon_e.lat));
      end
    end
    ack_prev <= dbg_ack;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rd, input bit chk_rd, input bit err, input int lat);
    exp_q.push_back('{exp_rd, chk_rd, err, lat});
    dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1;
    req_cyc = cyc;
  endtask

  task automatic wait_ack(input string name, input logic level);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dbg_ack !== level && n < 200);
    chk(name, {31'd0, dbg_ack}, {31'd0, level});
  endtask

  task automatic finish_req(input string name);
    wait_ack({name, "_ack_hi"}, 1'b1);
    tick();
    dbg_req = 1'b0;
    wait_ack({name, "_ack_lo"}, 1'b0);
  endtask

  task automatic prefill();
    for (int i = 1; i < 32; i++) begin
      tick();
      cpu_reg_write = 1'b1; cpu_write_register = 5'(i); cpu_write_data = 32'h1000_0000 | i;
    end
    tick();
    cpu_reg_write = 1'b0;
  endtask

  typedef struct {
    logic we; logic [4:0] wreg; logic [31:0] wdata; logic [4:0] rreg;
    logic exp_we; logic [4:0] exp_wreg; logic [31:0] exp_wdata; logic [4:0] exp_rreg;
  } cpu_vec_t;
  typedef struct { logic we; logic [4:0] addr; logic [31:0] wdata; logic [31:0] exp_rd; } dbg_vec_t;

  cpu_vec_t cv[4];
  dbg_vec_t dv[8];

  initial begin
    int log_start, n, p0, nz;
    bit ok;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int log_start, n, p0, nz;
    bit ok;
    cv[0] = '{1'b1, 5'd8,  32'h0000_1234, 5'd3,  1'b1, 5'd8,  32'h0000_1234, 5'd3};
    cv[1] = '{1'b0, 5'd17, 32'hFFFF_0000, 5'd8,  1'b0, 5'd17, 32'hFFFF_0000, 5'd8};
    cv[2] = '{1'b1, 5'd31, 32'h8000_0001, 5'd31, 1'b1, 5'd31, 32'h8000_0001, 5'd31};
    cv[3] = '{1'b1, 5'd1,  32'h0BAD_F00D, 5'd0,  1'b1, 5'd1,  32'h0BAD_F00D, 5'd0};
    dv[0] = '{1'b1, 5'd4,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    dv[1] = '{1'b0, 5'd4,  32'h0,         32'hDEAD_BEEF};
    dv[2] = '{1'b1, 5'd0,  32'h0000_0055, 32'h0000_0055};
    dv[3] = '{1'b0, 5'd0,  32'h0,         32'h0000_0000};
    dv[4] = '{1'b1, 5'd31, 32'h8000_0001, 32'h8000_0001};
    dv[5] = '{1'b0, 5'd31, 32'h0,         32'h8000_0001};
    dv[6] = '{1'b1, 5'd1,  32'h0000_0001, 32'h0000_0001};
    dv[7] = '{1'b0, 5'd8,  32'h0,         32'h0000_1234};

    reset = 1'b1;
    cpu_reg_write = 1'b0; cpu_write_register = '0; cpu_write_data = '0;
    cpu_read_register1 = '0; cpu_boundary = 1'b1;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_clear = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_dbg_ack",   {31'd0, dbg_ack},   32'd0);
    chk("rst_dbg_err",   {31'd0, dbg_err},   32'd0);
    chk("rst_clr_done",  {31'd0, clr_done},  32'd0);
    chk("rst_dbg_busy",  {31'd0, dbg_busy},  32'd0);
    chk("rst_dbg_rdata", dbg_rdata, 32'd0);
    tick();
    reset = 1'b0;

    // CPU pass-through while idle.
    for (int i = 0; i < 4; i++) begin
      tick();
      cpu_reg_write = cv[i].we; cpu_write_register = cv[i].wreg;
      cpu_write_data = cv[i].wdata; cpu_read_register1 = cv[i].rreg;
      @(negedge clk);
      chk($sformatf("pt%0d_we", i),    {31'd0, rf_reg_write}, {31'd0, cv[i].exp_we});
      chk($sformatf("pt%0d_wreg", i),  {27'd0, rf_write_register}, {27'd0, cv[i].exp_wreg});
      chk($sformatf("pt%0d_wdata", i), rf_write_data, cv[i].exp_wdata);
      chk($sformatf("pt%0d_rreg", i),  {27'd0, rf_read_register1}, {27'd0, cv[i].exp_rreg});
      chk($sformatf("pt%0d_stall", i), {31'd0, cpu_stall}, 32'd0);
    end
    tick();
    cpu_reg_write = 1'b0; cpu_read_register1 = 5'd0;

    // Debug access table at a boundary.
    for (int i = 0; i < 8; i++) begin
      tick();
      start_req(dv[i].we, dv[i].addr, dv[i].wdata, dv[i].exp_rd, 1'b1, 1'b0, 3);
      finish_req($sformatf("dv%0d", i));
    end
    chk("zero_write_dropped", 32'(zero_wr), 32'd0);

    // Read latency and stall release.
    tick();
    start_req(1'b0, 5'd4, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0, 3);
    wait_ack("lat_ack_hi", 1'b1);
    chk("lat_stall_in_ack", {31'd0, cpu_stall}, 32'd1);
    tick();
    dbg_req = 1'b0;
    @(negedge clk);
    chk("lat_stall_after_drop", {31'd0, cpu_stall}, 32'd1);
    tick();
    chk("lat_stall_released", {31'd0, cpu_stall}, 32'd0);
    chk("lat_ack_released", {31'd0, dbg_ack}, 32'd0);

    // Debug write while the CPU is mid-instruction.
    tick();
    cpu_boundary = 1'b0;
    cpu_reg_write = 1'b1; cpu_write_register = 5'd9; cpu_write_data = 32'h99;
    tick();
    cpu_reg_write = 1'b0;
    tick();
    chk("mid_cpu_wr9", rf[9], 32'h99);
    tick();
    start_req(1'b1, 5'd9, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 1'b0, -1);
    tick();
    cpu_reg_write = 1'b1; cpu_write_register = 5'd10; cpu_write_data = 32'h10;
    @(negedge clk);
    chk("mid_stall_wait", {31'd0, cpu_stall}, 32'd1);
    chk("mid_pt_we", {31'd0, rf_reg_write}, 32'd1);
    chk("mid_pt_wreg", {27'd0, rf_write_register}, 32'd10);
    tick();
    cpu_reg_write = 1'b0; cpu_boundary = 1'b1;
    finish_req("mid");
    chk("mid_rf9", rf[9], 32'hA5A5_A5A5);
    chk("mid_rf10", rf[10], 32'h10);

    // Bulk clear of a fully populated file.
    prefill();
    log_start = wr_log.size(); p0 = clr_pulses;
    dbg_clear = 1'b1;
    tick();
    dbg_clear = 1'b0;
    repeat (4) tick();
    chk("clr_stall", {31'd0, cpu_stall}, 32'd1);
    n = 0;
    do begin @(negedge clk); n++; end while (clr_done !== 1'b1 && n < 200);
    chk("clr_done_seen", {31'd0, clr_done}, 32'd1);
    repeat (3) tick();
    chk("clr_pulses", 32'(clr_pulses - p0), 32'd1);
    chk("clr_write_count", 32'(wr_log.size() - log_start), 32'd31);
    ok = (wr_log.size() - log_start) == 31;
    for (int j = 0; j < 31 && ok; j++)
      ok = (wr_log[log_start+j].addr == 5'(j + 1)) && (wr_log[log_start+j].data == 32'd0) &&
           (wr_log[log_start+j].cyc == wr_log[log_start].cyc + j);
    chk("clr_sweep_order", {31'd0, ok}, 32'd1);
    for (int r = 1; r < 32; r++) chk($sformatf("clr_rf%0d", r), rf[r], 32'd0);

    // Clear and write requested together: sweep first, then the write.
    prefill();
    log_start = wr_log.size();
    tick();
    dbg_clear = 1'b1;
    start_req(1'b1, 5'd2, 32'd7, 32'd7, 1'b1, 1'b0, -1);
    tick();
    dbg_clear = 1'b0;
    finish_req("simul");
    chk("simul_rf2", rf[2], 32'd7);
    nz = 0;
    for (int r = 1; r < 32; r++) if (r != 2 && rf[r] != 32'd0) nz++;
    chk("simul_others_zero", 32'(nz), 32'd0);
    chk("simul_write_count", 32'(wr_log.size() - log_start), 32'd32);
    chk("simul_last_addr", {27'd0, wr_log[wr_log.size()-1].addr}, 32'd2);

    // Boundary never arrives: timeout with error, no register touched.
    tick();
    cpu_boundary = 1'b0;
    log_start = wr_log.size();
    start_req(1'b0, 5'd5, 32'h0, 32'h0, 1'b0, 1'b1, 5);
    finish_req("tmo");
    chk("tmo_err_cleared", {31'd0, dbg_err}, 32'd0);
    chk("tmo_no_write", 32'(wr_log.size() - log_start), 32'd0);
    tick();
    cpu_boundary = 1'b1;

    // Asynchronous reset in the middle of a sweep.
    tick();
    dbg_clear = 1'b1;
    tick();
    dbg_clear = 1'b0;
    repeat (6) tick();
    chk("rstclr_busy_before", {31'd0, dbg_busy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstclr_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rstclr_busy", {31'd0, dbg_busy}, 32'd0);
    chk("rstclr_rf_we", {31'd0, rf_reg_write}, 32'd0);
    n = wr_log.size();
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("rstclr_no_more_writes", 32'(wr_log.size() - n), 32'd0);
    chk("rstclr_idle_after", {31'd0, dbg_busy}, 32'd0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
